// File: rtl/bsg_manycore_host_req_scheduler_if.sv
// Request-path bundle between the host-side request sources, the scheduler
// and the manycore endpoint host_req port.
//
// Signals (direction given from the scheduler's point of view):
//   req_v_i          in   per-requester valid
//   req_data_i       in   packed request data, requester i at [i*fifo_width_p +: fifo_width_p]
//   req_yumi_o       out  one-hot accept back to the requesters
//   host_req_o       out  packet to the endpoint
//   host_req_v_o     out  valid to the endpoint
//   host_req_ready_i in   endpoint ready
//   out_credits_i    in   endpoint's available out-credits
//   fence_v_i        in   fence request (level)
//   fence_done_o     out  one-cycle fence completion pulse
//   busy_o           out  fence in progress
//   issue_count_o    out  running count of issued requests (wraps)
//
// master: the scheduler.  slave: the environment (requesters + endpoint).
interface bsg_manycore_host_req_scheduler_if #(
  parameter int num_req_p         = 2,
  parameter int fifo_width_p      = 32,
  parameter int max_out_credits_p = 8
);
  localparam int credit_width_lp = $clog2(max_out_credits_p + 1);

  logic [num_req_p-1:0]              req_v_i;
  logic [num_req_p*fifo_width_p-1:0] req_data_i;
  logic [num_req_p-1:0]              req_yumi_o;
  logic [fifo_width_p-1:0]           host_req_o;
  logic                              host_req_v_o;
  logic                              host_req_ready_i;
  logic [credit_width_lp-1:0]        out_credits_i;
  logic                              fence_v_i;
  logic                              fence_done_o;
  logic                              busy_o;
  logic [31:0]                       issue_count_o;

  modport master (
    input  req_v_i, req_data_i, host_req_ready_i, out_credits_i, fence_v_i,
    output req_yumi_o, host_req_o, host_req_v_o, fence_done_o, busy_o, issue_count_o
  );

  modport slave (
    output req_v_i, req_data_i, host_req_ready_i, out_credits_i, fence_v_i,
    input  req_yumi_o, host_req_o, host_req_v_o, fence_done_o, busy_o, issue_count_o
  );
endinterface

// File: rtl/bsg_manycore_host_req_scheduler.sv
// Shares the single host->manycore request path among num_req_p request
// sources. Round-robin arbitration, issue gated on endpoint out-credits with a
// one-cycle bubble after every issue so the endpoint's credit update is seen
// before the next issue. A fence blocks issue until all credits have returned
// and then emits a single fence_done_o pulse.
//
// Ports:
//   clk_i    clock
//   reset_i  synchronous active-high reset
//   bus      request/endpoint bundle (master modport), see the interface file
module bsg_manycore_host_req_scheduler #(
  parameter int num_req_p         = 2,
  parameter int fifo_width_p      = 32,
  parameter int max_out_credits_p = 8
) (
  input logic clk_i,
  input logic reset_i,
  bsg_manycore_host_req_scheduler_if.master bus
);
  localparam int credit_width_lp = $clog2(max_out_credits_p + 1);
  localparam int ptr_w_lp        = $clog2(num_req_p);

  typedef enum logic [1:0] {IDLE, FENCE, DONE} state_e;

  state_e              state_q;
  logic [ptr_w_lp-1:0] rr_ptr_q;
  logic [ptr_w_lp-1:0] rr_ptr_d;
  logic [ptr_w_lp-1:0] winner;
  logic                last_issue_q;
  logic                fence_done_q;
  logic                busy_q;
  logic [31:0]         issue_count_q;
  logic                issue_ok;
  logic                hs;
  logic                credits_full;

  assign credits_full = (bus.out_credits_i == credit_width_lp'(max_out_credits_p));

  // Upward scan from the round-robin pointer, wrapping at num_req_p.
  always_comb begin
    logic                found;
    int                  cand;
    logic [ptr_w_lp-1:0] cidx;
    winner = '0;
    found  = 1'b0;
    cand   = 0;
    cidx   = '0;
    for (int k = 0; k < num_req_p; k++) begin
      cand = (int'(rr_ptr_q) + k) % num_req_p;
      cidx = ptr_w_lp'(cand);
      if (!found && bus.req_v_i[cidx]) begin
        found  = 1'b1;
        winner = cidx;
      end
    end
  end

  // last_issue_q is the credit-lag bubble; reset_i masks the request path so
  // nothing is offered to the endpoint while the block is held in reset.
  assign issue_ok = ~reset_i & (state_q == IDLE) & ~bus.fence_v_i
                  & (bus.out_credits_i != '0) & ~last_issue_q;

  assign bus.host_req_v_o = issue_ok & (|bus.req_v_i);
  assign bus.host_req_o   = bus.req_data_i[int'(winner)*fifo_width_p +: fifo_width_p];
  assign hs               = bus.host_req_v_o & bus.host_req_ready_i;

  always_comb begin
    bus.req_yumi_o = '0;
    if (hs) bus.req_yumi_o[winner] = 1'b1;
  end

  assign rr_ptr_d = (winner == ptr_w_lp'(num_req_p - 1)) ? '0 : winner + ptr_w_lp'(1);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      last_issue_q  <= 1'b0;
      issue_count_q <= '0;
      fence_done_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      last_issue_q <= hs;
      if (hs) begin
        rr_ptr_q      <= rr_ptr_d;
        issue_count_q <= issue_count_q + 32'd1;
      end
      case (state_q)
        IDLE: begin
          if (bus.fence_v_i) begin
            state_q <= FENCE;
            busy_q  <= 1'b1;
          end
        end
        // fence_v_i is not consulted here: once started, a fence always completes.
        FENCE: begin
          if (credits_full && !last_issue_q) begin
            state_q      <= DONE;
            fence_done_q <= 1'b1;
          end
        end
        DONE: begin
          state_q      <= IDLE;
          fence_done_q <= 1'b0;
          busy_q       <= 1'b0;
        end
        default: begin
          state_q      <= IDLE;
          fence_done_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fence_done_o  = fence_done_q;
  assign bus.busy_o        = busy_q;
  assign bus.issue_count_o = issue_count_q;
endmodule

// File: tb/tb_bsg_manycore_host_req_scheduler.sv
module tb_bsg_manycore_host_req_scheduler;
  localparam int N    = 4;
  localparam int W    = 16;
  localparam int MAXC = 8;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int NCYC = 3000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bsg_manycore_host_req_scheduler_if #(.num_req_p(N), .fifo_width_p(W), .max_out_credits_p(MAXC)) bus();

  bsg_manycore_host_req_scheduler #(
    .num_req_p(N), .fifo_width_p(W), .max_out_credits_p(MAXC)
  ) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .bus    (bus)
  );

  typedef struct {
    int          cyc;
    bit          chk;
    bit          busy;
    bit          done;
    bit          vld;
    logic [N-1:0] yumi;
    logic [31:0] cnt;
  } cyc_t;

  typedef struct {
    int          cyc;
    int          idx;
    logic [W-1:0] data;
  } hs_t;

  cyc_t cq[$];
  hs_t  hq[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string nm, input int c, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, c, got, exp);
    end
  endtask

  // Reference model: fence mode (0 idle, 1 fencing, 2 done-pulse), next
  // requester with priority, whether the previous cycle issued, issue total.
  int          m_mode   = 0;
  int          m_prio   = 0;
  bit          m_bubble = 1'b0;
  logic [31:0] m_issued = '0;

  task automatic model_step(input logic [N-1:0] v, input bit rdy, input int cred, input bit fen,
                            input bit r, output bit e_v, output bit e_hs, output int e_w,
                            output bit e_busy, output bit e_done);
    bit found;
    e_busy = (m_mode != 0);
    e_done = (m_mode == 2);
    e_v    = 1'b0;
    e_w    = 0;
    found  = 1'b0;
    if (!r && m_mode == 0 && !fen && cred != 0 && !m_bubble && v != '0) begin
      e_v = 1'b1;
      for (int k = 0; k < N; k++) begin
        if (!found && v[(m_prio + k) % N]) begin
          found = 1'b1;
          e_w   = (m_prio + k) % N;
        end
      end
    end
    e_hs = e_v && rdy;
    if (r) begin
      m_mode = 0; m_prio = 0; m_bubble = 1'b0; m_issued = '0;
    end else begin
      if (m_mode == 0 && fen)                          m_mode = 1;
      else if (m_mode == 1 && cred == MAXC && !m_bubble) m_mode = 2;
      else if (m_mode == 2)                            m_mode = 0;
      m_bubble = e_hs;
      if (e_hs) begin
        m_prio   = (e_w + 1) % N;
        m_issued = m_issued + 32'd1;
      end
    end
  endtask

  // Driver: random segments that stress round-robin, credit starvation,
  // credit-ramp fences, held fences and resets.
  initial begin
    logic [W-1:0] pkt [N];
    logic [N-1:0] v;
    bit   rdy, fen, r;
    int   cred, mode, seg_left, seg_len, base;
    bit   e_v, e_hs, e_busy, e_done;
    int   e_w;
    cyc_t ce;
    hs_t  he;

    rst = 1'b1;
    bus.req_v_i = '0;
    bus.req_data_i = '0;
    bus.host_req_ready_i = 1'b0;
    bus.out_credits_i = '0;
    bus.fence_v_i = 1'b0;
    for (int i = 0; i < N; i++) pkt[i] = W'($urandom);
    mode = 0; seg_left = 0; seg_len = 1; base = 0;

    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      cyc = c;
      if (seg_left == 0) begin
        mode     = $urandom_range(0, 5);
        seg_len  = $urandom_range(20, 60);
        seg_left = seg_len;
        base     = $urandom_range(3, 7);
      end
      seg_left--;
      v = N'($urandom); rdy = 1'b1; cred = MAXC; fen = 1'b0; r = 1'b0;
      case (mode)
        0: begin
          rdy  = ($urandom_range(0, 3) != 0);
          cred = $urandom_range(0, MAXC);
          fen  = ($urandom_range(0, 15) == 0);
        end
        1: begin
          v   = '1;
          rdy = ($urandom_range(0, 5) != 0);
        end
        2: cred = ($urandom_range(0, 3) == 0) ? 1 : 0;
        3: begin
          fen  = (seg_left == seg_len - 1);
          cred = base + (seg_len - 1 - seg_left) / 4;
          if (cred > MAXC) cred = MAXC;
        end
        4: begin
          fen  = 1'b1;
          cred = $urandom_range(MAXC - 1, MAXC);
          r    = ($urandom_range(0, 15) == 0);
        end
        default: begin
          rdy  = ($urandom_range(0, 3) != 0);
          fen  = ($urandom_range(0, 7) == 0);
          cred = $urandom_range(0, MAXC);
          r    = ($urandom_range(0, 9) == 0);
        end
      endcase
      if (c < 2) r = 1'b1;

      rst = r;
      bus.req_v_i = v;
      for (int i = 0; i < N; i++) bus.req_data_i[i*W +: W] = pkt[i];
      bus.host_req_ready_i = rdy;
      bus.out_credits_i = CW'(cred);
      bus.fence_v_i = fen;

      ce.cnt = m_issued;
      model_step(v, rdy, cred, fen, r, e_v, e_hs, e_w, e_busy, e_done);
      ce.cyc  = c;
      ce.chk  = (c != 0);
      ce.busy = e_busy;
      ce.done = e_done;
      ce.vld  = e_v;
      ce.yumi = e_hs ? N'(1 << e_w) : '0;
      cq.push_back(ce);
      if (e_hs) begin
        he.cyc  = c;
        he.idx  = e_w;
        he.data = pkt[e_w];
        hq.push_back(he);
        pkt[e_w] = W'($urandom);
      end
    end
    #2;
    check("hs_queue_drained", cyc, 32'(hq.size()), 32'd0);
    check("cyc_queue_drained", cyc, 32'(cq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Monitor: compares settled DUT outputs mid-cycle against the scoreboard.
  initial begin
    cyc_t e;
    hs_t  h;
    forever begin
      @(negedge clk);
      #1;
      if (cq.size() > 0) begin
        e = cq.pop_front();
        if (e.chk) begin
          check("busy", e.cyc, 32'(bus.busy_o), 32'(e.busy));
          check("fence_done", e.cyc, 32'(bus.fence_done_o), 32'(e.done));
          check("host_req_v", e.cyc, 32'(bus.host_req_v_o), 32'(e.vld));
          check("yumi", e.cyc, 32'(bus.req_yumi_o), 32'(e.yumi));
          check("issue_count", e.cyc, bus.issue_count_o, e.cnt);
        end
      end
      if (bus.host_req_v_o && bus.host_req_ready_i) begin
        if (hq.size() == 0) begin
          check("hs_unexpected", cyc, 32'd1, 32'd0);
        end else begin
          h = hq.pop_front();
          check("hs_cycle", cyc, 32'(cyc), 32'(h.cyc));
          check("hs_grant", cyc, 32'(bus.req_yumi_o), 32'(1 << h.idx));
          check("hs_data", cyc, 32'(bus.host_req_o), 32'(h.data));
        end
      end
    end
  end
endmodule
